// File: rtl/core_run_sequencer.sv
// Host run controller: shares the 256-byte program RAM port between host LOAD/READ
// commands and the stack-machine core, and sequences core reset/run/halt. Watchdog: SEQ_WATCHDOG_EN.
module core_run_sequencer #(
    parameter int CYC_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_addr,
    input  logic [7:0]       cmd_data,
    output logic             rsp_valid,
    output logic [7:0]       rsp_data,
    output logic             err,
    output logic             core_reset,
    input  logic [7:0]       core_mem_addr,
    input  logic             core_mem_we,
    input  logic [7:0]       core_data_out,
    input  logic             core_halt,
    output logic [7:0]       core_data_in,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             mem_we,
    input  logic [7:0]       mem_rdata,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [7:0]       result,
    output logic [CYC_W-1:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WR,
        S_READ_RD,
        S_RUN_RST,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam logic [1:0] OP_ABORT = 2'd3;

    if (TIMEOUT_CYCLES < 1 || (TIMEOUT_CYCLES >> CYC_W) != 0) begin : g_bad_timeout
        $error("core_run_sequencer: TIMEOUT_CYCLES must be in [1, 2^CYC_W)");
    end

    state_t           state_q, state_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       result_q, result_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic             cmd_fire;
    logic             wd_hit;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

`ifdef SEQ_WATCHDOG_EN
    localparam logic [CYC_W-1:0] WD_LAST = CYC_W'(TIMEOUT_CYCLES - 1);
    assign wd_hit = (cycles_q == WD_LAST);
`else
    assign wd_hit = 1'b0;
`endif

    // Port ownership: the core drives the RAM only while actually running.
    always_comb begin
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        core_reset = 1'b1;
        mem_addr   = 8'h00;
        mem_wdata  = wdata_q;
        mem_we     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: cmd_ready = 1'b1;
            S_LOAD_WR: begin
                busy     = 1'b1;
                mem_addr = addr_q;
                mem_we   = 1'b1;
            end
            S_READ_RD: begin
                busy     = 1'b1;
                mem_addr = addr_q;
            end
            S_RUN_RST: busy = 1'b1;
            S_RUN: begin
                cmd_ready  = 1'b1;
                busy       = 1'b1;
                core_reset = 1'b0;
                mem_addr   = core_mem_addr;
                mem_wdata  = core_data_out;
                mem_we     = core_mem_we;
            end
            default: ;
        endcase
    end

    assign cmd_fire = cmd_valid & cmd_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        err_d       = 1'b0;
        done_d      = done_q;
        timeout_d   = timeout_q;
        result_d    = result_q;
        cycles_d    = cycles_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            addr_d  = cmd_addr;
                            wdata_d = cmd_data;
                            state_d = S_LOAD_WR;
                        end
                        OP_READ: begin
                            addr_d  = cmd_addr;
                            state_d = S_READ_RD;
                        end
                        OP_RUN: begin
                            done_d    = 1'b0;
                            timeout_d = 1'b0;
                            result_d  = 8'h00;
                            cycles_d  = '0;
                            state_d   = S_RUN_RST;
                        end
                        OP_ABORT: begin
                            done_d    = 1'b0;
                            timeout_d = 1'b0;
                            state_d   = S_IDLE;
                        end
                    endcase
                end
            end
            S_LOAD_WR: state_d = S_IDLE;
            S_READ_RD: begin
                rsp_data_d  = mem_rdata;
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_RUN_RST: state_d = S_RUN;
            S_RUN: begin
                cycles_d = sat_inc(cycles_q);
                if (cmd_fire && cmd_op != OP_ABORT) begin
                    err_d = 1'b1;
                end
                // A halt always beats the watchdog and an abort landing in the same cycle.
                if (core_halt) begin
                    result_d = core_data_out;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (wd_hit) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    result_d  = 8'h00;
                    state_d   = S_DONE;
                end else if (cmd_fire && cmd_op == OP_ABORT) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            result_q    <= 8'h00;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            result_q    <= result_d;
            cycles_q    <= cycles_d;
        end
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign core_data_in = mem_rdata;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign err          = err_q;
    assign done         = done_q;
    assign timeout      = timeout_q;
    assign result       = result_q;
    assign cycles       = cycles_q;

endmodule

// File: doc/core_run_sequencer.md
# core_run_sequencer

Host-side run controller for the stack-machine core. It owns the single 8-bit program/data memory port and multiplexes it between a host command interface (byte load/read) and the core. It sequences the core through reset, run and halt, and captures the final result and run-cycle count. It sits between the host link, the core, and the 256-byte program RAM.

## Interface
Parameters:
- CYC_W, 16, width of the run-cycle counter.
- TIMEOUT_CYCLES, 4096, watchdog limit in RUN cycles. Used only with the watchdog compiled in; must satisfy 1 ≤ TIMEOUT_CYCLES < 2^CYC_W.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  sequencer accepts the command; handshake = valid & ready at posedge.
- cmd_op  in  2  0 LOAD, 1 READ, 2 RUN, 3 ABORT.
- cmd_addr  in  8  memory address for LOAD/READ.
- cmd_data  in  8  write byte for LOAD.
- rsp_valid  out  1  one-cycle pulse: rsp_data valid.
- rsp_data  out  8  READ result.
- err  out  1  one-cycle pulse: command rejected.
- core_reset  out  1  synchronous reset to the core.
- core_mem_addr  in  8  core memory address.
- core_mem_we  in  1  core write strobe.
- core_data_out  in  8  core write data / result.
- core_halt  in  1  core is in its FIN state.
- core_data_in  out  8  read data to the core.
- mem_addr  out  8  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_we  out  1  RAM write enable. RAM has a combinational read and a write at posedge.
- mem_rdata  in  8  RAM read data.
- busy  out  1  state is LOAD_WR, READ_RD, RUN_RST or RUN.
- done  out  1  sticky: run finished.
- timeout  out  1  sticky: run ended by the watchdog.
- result  out  8  captured core_data_out.
- cycles  out  CYC_W  RUN cycles elapsed; saturates at all-ones.

## Operation
- States: IDLE, LOAD_WR, READ_RD, RUN_RST, RUN, DONE.
- Reset (overrides everything, including mid-run): state IDLE, core_reset=1, all other registered outputs 0.
- IDLE/DONE: cmd_ready=1. In each of these states, core_reset=1, mem_addr=0 and mem_we=0.
- LOAD handshake: latch addr/data and go to LOAD_WR.
  - LOAD_WR: mem_addr=addr, mem_wdata=data, mem_we=1, cmd_ready=0; then go to IDLE.
- READ handshake: latch addr and go to READ_RD.
  - READ_RD: mem_addr=addr, cmd_ready=0; register mem_rdata into rsp_data and set rsp_valid; then go to IDLE.
- RUN handshake: clear done, timeout, result and cycles; go to RUN_RST.
  - RUN_RST: core_reset=1 for exactly one cycle; then go to RUN.
- RUN: core_reset=0.
  - Memory is muxed to the core: mem_addr=core_mem_addr, mem_we=core_mem_we, mem_wdata=core_data_out, core_data_in=mem_rdata.
  - cycles increments each RUN cycle.
  - cmd_ready=1. ABORT is taken. Any other op is consumed, err pulses, and there is no other effect.
- core_halt in RUN: result←core_data_out, done←1, go to DONE.
- Watchdog: a RUN cycle with cycles==TIMEOUT_CYCLES-1 and core_halt=0 sets timeout←1, done←1, result←0, and goes to DONE.
  - Halt and the watchdog limit in the same cycle: halt wins, timeout stays 0.
- ABORT:
  - In RUN: go to IDLE. done stays 0; cycles and result are held.
  - In IDLE/DONE: go to IDLE and clear done/timeout.
- LOAD/READ from DONE leave done, timeout and result intact.
- core_data_in=mem_rdata in all states. The core ignores it while held in reset.

## Timing
- LOAD: handshake at edge N; write commits at edge N+1; cmd_ready is high again in cycle N+1. Throughput is 1 byte per 2 cycles.
- READ: handshake at edge N; rsp_valid is high in cycle N+1..N+2, for one cycle only.
- RUN: handshake at edge N; core_reset=1 during RUN_RST; the first RUN cycle begins at edge N+1, with the core presenting pc=0.
- core_halt sampled in the k-th RUN cycle gives done=1, result and cycles=k visible in the next cycle.
- err and rsp_valid are registered, single-cycle pulses.

## Configuration
- SEQ_WATCHDOG_EN defined: the watchdog compare and timeout flag are implemented as specified above.
- SEQ_WATCHDOG_EN undefined:
  - No compare logic; TIMEOUT_CYCLES is ignored.
  - timeout is tied 0.
  - RUN ends only on core_halt, ABORT or reset; cycles still counts and saturates.

## Test plan
- Reset: expect core_reset=1, cmd_ready=1, busy=0, done=0, timeout=0, cycles=0, rsp_valid=0, err=0.
- LOAD 0x0D@0x00, 0x2A@0x01, 0x1A@0x02, then READ 0x01: expect rsp_valid pulse with rsp_data=0x2A two cycles after the READ handshake, and RAM holds all 3 bytes.
- RUN, core model asserts core_halt in RUN cycle 10 with core_data_out=0x2A: expect done=1, result=0x2A, cycles=10, core_reset=1 from the following cycle.
- With SEQ_WATCHDOG_EN and TIMEOUT_CYCLES=16, core never halts: expect timeout=1, done=1, result=0x00, cycles=16. Repeat with halt in cycle 16: expect timeout=0, result captured.
- LOAD issued during RUN: expect err pulse and RAM unchanged. ABORT in RUN cycle 5: expect IDLE, core_reset=1, done=0, cycles=5.
- Reset asserted mid-RUN at cycle 3: expect IDLE next cycle, core_reset=1, cycles=0, mem_we=0.
